freq_calc: RTL and testbench
============================

# freq_calc

Downstream stage of the frequency meter: consumes the gated-count result (`cnt_s`, `cnt_x`, `irq`) of the measurement block and converts it to an integer frequency in Hz, freq = cnt_x · CLK_FREQ / cnt_s, using a registered multiply and a bit-serial 64/32 divider. It also runs a no-result watchdog that drives the measurement block's `meas_rst` input when no measurement arrives, and flags signal loss.

## Interface
- `CLK_FREQ`, default 100_000_000: reference clock in Hz; multiplier constant, must fit 32 bits.
- `TIMEOUT_CYC`, default 200_000_000: watchdog period in clk cycles (2 s at 100 MHz); must be ≥ 2.
- `clk_100M`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  1  measurement-complete level from the measurement block; its rising edge starts a calculation.
- `cnt_s`  in  32  standard-clock count; sampled on the `irq` rising edge.
- `cnt_x`  in  32  signal count; sampled on the `irq` rising edge.
- `freq_hz`  out  32  last valid frequency in Hz; holds its value between results.
- `freq_valid`  out  1  one-cycle pulse; `freq_hz` is updated in the same cycle.
- `busy`  out  1  high in every state except IDLE.
- `div_err`  out  1  one-cycle pulse when `cnt_s` == 0 is sampled.
- `drop`  out  1  one-cycle pulse when an `irq` rising edge arrives while `busy`.
- `meas_rst`  out  1  one-cycle watchdog pulse to the measurement block.
- `sig_lost`  out  1  sticky loss flag: set by a watchdog expiry, cleared by `freq_valid`.

## Operation
- Edge detect: `irq_d` is a register of `irq`. A start is `irq & ~irq_d`. `irq_d` resets to 0, so an `irq` that is high straight out of reset counts as an edge.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: on a start, latch `cnt_s`/`cnt_x` into `den`/`xr`.
  - If `cnt_s` == 0: pulse `div_err`, stay in IDLE, leave `freq_hz` unchanged, no `freq_valid`.
  - Otherwise go to MUL.
- MUL (1 cycle): `num` = `xr` · CLK_FREQ, as a 64-bit unsigned product. Add `den`>>1 when rounding is enabled. Go to DIV.
- DIV (64 cycles): restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder; 64-bit quotient shift register.
  - Iteration counter 6 bits; leave DIV when it wraps from 63.
- DONE (1 cycle): if quotient[63:32] ≠ 0, `freq_hz` = 0xFFFF_FFFF (saturate); otherwise `freq_hz` = quotient[31:0]. Pulse `freq_valid`, return to IDLE.
- A start seen in MUL, DIV or DONE is discarded and pulses `drop`. The operands in flight are unaffected.
- Watchdog: 32-bit counter counts up every cycle and clears on any start (accepted or dropped).
  - When the count equals TIMEOUT_CYC−1: pulse `meas_rst`, set `sig_lost`, clear the counter.
  - A start in the same cycle wins: counter clears, no `meas_rst`.
- `sig_lost` clears on `freq_valid`. If set and clear coincide, set wins.
- Reset mid-operation: FSM returns to IDLE and the in-flight result is lost.

## Timing
- Reset value of every output: `freq_hz` = 0; `freq_valid`, `busy`, `div_err`, `drop`, `meas_rst`, `sig_lost` = 0. Internal registers also reset to 0.
- Cycle 0 is the clock edge at which the start is sampled and the operands latched. `busy` is high from cycle 1.
- MUL occupies cycle 1, DIV cycles 2–65, DONE cycle 66.
- `freq_valid` and the new `freq_hz` are visible after edge 66 and `freq_valid` is high for exactly one cycle. Latency is 66 cycles; `busy` falls at edge 67.
- `div_err` and `drop` are high for the cycle following the sampling edge.
- Throughput: one result per 67 cycles, far shorter than any gate period.

## Configuration
- Macro `FREQ_CALC_ROUND_EN`.
- Defined: `num` += `den`>>1 before division, giving round-to-nearest (ties round up).
- Undefined: plain truncation; the adder is not built.
- All other behaviour is identical with or without the macro.

## Structure
- Package `freq_calc_pkg` holds:
  - FSM state typedef (IDLE/MUL/DIV/DONE);
  - `NUM_W` = 64, `DEN_W` = 32, `DIV_ITER` = 64;
  - the saturation constant 32'hFFFF_FFFF.
- One sub-module, `seq_div64`: a start/done restoring divider taking a 64-bit numerator and 32-bit denominator and producing a 64-bit quotient in 64 cycles. The top module keeps the FSM, MUL stage, watchdog and output registers.

## Test plan
- `cnt_x` = 1_000_000, `cnt_s` = 100_000_000, `irq` 0→1 → `freq_valid` exactly 66 cycles later, `freq_hz` = 1_000_000; `busy` high for cycles 1–66.
- `cnt_x` = 2, `cnt_s` = 3 → `freq_hz` = 66_666_667 with `FREQ_CALC_ROUND_EN`, 66_666_666 without.
- `cnt_s` = 0 with `freq_hz` = 5 from a prior result → one-cycle `div_err`, no `freq_valid`, `freq_hz` stays 5, `busy` never rises.
- `cnt_x` = 0xFFFF_FFFF, `cnt_s` = 1 → `freq_hz` = 0xFFFF_FFFF.
- Second `irq` edge (`irq` toggled low then high) at cycle 30 of DIV → one `drop` pulse; only the first result is produced.
- `TIMEOUT_CYC` = 1000, no `irq` after reset → `meas_rst` pulse at cycle 999 and `sig_lost` = 1. A following valid measurement clears `sig_lost`. `rst` asserted at DIV cycle 10 → all outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/freq_calc_pkg.sv
// freq_calc shared types and constants.
// FSM states, datapath widths, saturation value.
package freq_calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam int NUM_W    = 64;
  localparam int DEN_W    = 32;
  localparam int DIV_ITER = 64;

  localparam logic [31:0] FREQ_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/freq_calc_seq_div64.sv
// seq_div64: restoring 64/32 divider, one bit per cycle.
// clk/rst, start (loads num and runs first step), num, den, quo, done.
module seq_div64
  import freq_calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo,
  output logic             done
);

  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

  logic [DEN_W-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             act_q;

  logic [DEN_W-1:0] r_src;
  logic [NUM_W-1:0] q_src;
  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic             fit;

  // The start cycle already retires quotient bit 63 from num.
  // Remainder stays below den, so the borrow of the 33-bit
  // trial subtraction alone decides the quotient bit.
  always_comb begin
    r_src = start ? '0 : rem_q;
    q_src = start ? num : quo;
    trial = {r_src, q_src[NUM_W-1]};
    diff  = trial - {1'b0, den};
    fit   = ~diff[DEN_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start || act_q) begin
      rem_q <= fit ? diff[DEN_W-1:0]
                   : trial[DEN_W-1:0];
      quo   <= {q_src[NUM_W-2:0], fit};
      if (start) begin
        cnt_q <= CW'(1);
        act_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        act_q <= (cnt_q != LAST);
      end
    end
  end

  assign done = act_q && !start && (cnt_q == LAST);

endmodule

// File: rtl/freq_calc.sv
// freq_calc: cnt_x*CLK_FREQ/cnt_s in Hz plus no-result watchdog.
// In: clk_100M, rst, irq, cnt_s, cnt_x. Out: freq_hz, freq_valid,
// busy, div_err, drop, meas_rst, sig_lost.
// FREQ_CALC_ROUND_EN: round-to-nearest instead of truncation.
module freq_calc
  import freq_calc_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 200_000_000
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        irq,
  input  logic [31:0] cnt_s,
  input  logic [31:0] cnt_x,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        busy,
  output logic        div_err,
  output logic        drop,
  output logic        meas_rst,
  output logic        sig_lost
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             irq_d;
  logic [DEN_W-1:0] den;
  logic [DEN_W-1:0] xr;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] num_d;
  logic [NUM_W-1:0] quo;
  logic             div_go;
  logic             div_done;
  logic [31:0]      wd_cnt;
  logic             start;
  logic             wd_hit;

  assign start  = irq & ~irq_d;
  assign wd_hit = !start && (wd_cnt == WD_LAST);

  always_comb begin
    num_d = {32'b0, xr} * NUM_W'(CLK_FREQ);
`ifdef FREQ_CALC_ROUND_EN
    num_d = num_d + NUM_W'(den >> 1);
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE:
        if (start && cnt_s != '0) state_d = MUL;
      state_q == MUL:
        state_d = DIV;
      state_q == DIV:
        if (div_done) state_d = DONE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  seq_div64 u_div (
    .clk   (clk_100M),
    .rst   (rst),
    .start (div_go),
    .num   (num),
    .den   (den),
    .quo   (quo),
    .done  (div_done)
  );

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      irq_d      <= 1'b0;
      den        <= '0;
      xr         <= '0;
      num        <= '0;
      div_go     <= 1'b0;
      wd_cnt     <= '0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
      busy       <= 1'b0;
      div_err    <= 1'b0;
      drop       <= 1'b0;
      meas_rst   <= 1'b0;
      sig_lost   <= 1'b0;
    end else begin
      irq_d      <= irq;
      freq_valid <= 1'b0;
      div_err    <= 1'b0;
      drop       <= 1'b0;
      meas_rst   <= 1'b0;
      busy       <= (state_q != IDLE);
      div_go     <= (state_q == MUL);

      if (start) begin
        if (state_q == IDLE) begin
          den     <= cnt_s;
          xr      <= cnt_x;
          div_err <= (cnt_s == '0);
        end else begin
          drop <= 1'b1;
        end
      end

      if (state_q == MUL) num <= num_d;

      if (state_q == DONE) begin
        freq_valid <= 1'b1;
        freq_hz    <= (quo[63:32] != '0) ? FREQ_SAT
                                         : quo[31:0];
      end

      if (start || wd_hit) wd_cnt <= '0;
      else                 wd_cnt <= wd_cnt + 32'd1;

      if (wd_hit) meas_rst <= 1'b1;

      if (wd_hit)                 sig_lost <= 1'b1;
      else if (state_q == DONE)   sig_lost <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: vector table plus
// watchdog, drop and mid-operation reset sequences.
module tb_freq_calc;

  logic        clk_100M;
  logic        rst;
  logic        irq;
  logic [31:0] cnt_s;
  logic [31:0] cnt_x;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        busy;
  logic        div_err;
  logic        drop;
  logic        meas_rst;
  logic        sig_lost;

  freq_calc #(
    .CLK_FREQ    (100_000_000),
    .TIMEOUT_CYC (1000)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .irq        (irq),
    .cnt_s      (cnt_s),
    .cnt_x      (cnt_x),
    .freq_hz    (freq_hz),
    .freq_valid (freq_valid),
    .busy       (busy),
    .div_err    (div_err),
    .drop       (drop),
    .meas_rst   (meas_rst),
    .sig_lost   (sig_lost)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  typedef struct {
    logic [31:0] cx;
    logic [31:0] cs;
    logic [31:0] f_tr;
    logic [31:0] f_rn;
    logic        err;
  } vec_t;

  vec_t tbl [10];
  int   n_chk;
  int   n_pass;

  task automatic tick;
    @(posedge clk_100M);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    logic [31:0] exp_f;
    int          n;
    int          cnt_a;
    int          cnt_b;
    logic        busy1;

    n_chk  = 0;
    n_pass = 0;

    tbl[0] = '{32'd1_000_000, 32'd100_000_000,
               32'd1_000_000, 32'd1_000_000, 1'b0};
    tbl[1] = '{32'd2, 32'd3,
               32'd66_666_666, 32'd66_666_667, 1'b0};
    tbl[2] = '{32'd5, 32'd100_000_000,
               32'd5, 32'd5, 1'b0};
    tbl[3] = '{32'd7, 32'd0,
               32'd5, 32'd5, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[5] = '{32'd3, 32'd7,
               32'd42_857_142, 32'd42_857_143, 1'b0};
    tbl[6] = '{32'd0, 32'd9,
               32'd0, 32'd0, 1'b0};
    tbl[7] = '{32'd1, 32'd1,
               32'd100_000_000, 32'd100_000_000, 1'b0};
    tbl[8] = '{32'd50, 32'd2,
               32'd2_500_000_000, 32'd2_500_000_000, 1'b0};
    tbl[9] = '{32'd100, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    rst   = 1'b1;
    irq   = 1'b0;
    cnt_s = '0;
    cnt_x = '0;
    tick;
    tick;
    check("rst_freq_hz", freq_hz, 32'd0);
    check("rst_valid", 32'(freq_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_err", 32'(div_err), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_meas_rst", 32'(meas_rst), 32'd0);
    check("rst_sig_lost", 32'(sig_lost), 32'd0);

    // Watchdog: no irq, expiry on the 1000th edge.
    rst   = 1'b0;
    cnt_a = 0;
    repeat (999) begin
      tick;
      cnt_a += int'(meas_rst);
    end
    check("wd_early", 32'(cnt_a), 32'd0);
    check("wd_lost_early", 32'(sig_lost), 32'd0);
    tick;
    check("wd_meas_rst", 32'(meas_rst), 32'd1);
    check("wd_sig_lost", 32'(sig_lost), 32'd1);
    tick;
    check("wd_pulse_end", 32'(meas_rst), 32'd0);
    check("wd_lost_held", 32'(sig_lost), 32'd1);

    for (int i = 0; i < 10; i++) begin
`ifdef FREQ_CALC_ROUND_EN
      exp_f = tbl[i].f_rn;
`else
      exp_f = tbl[i].f_tr;
`endif
      cnt_x = tbl[i].cx;
      cnt_s = tbl[i].cs;
      irq   = 1'b1;
      tick;
      check($sformatf("v%0d_div_err", i),
            32'(div_err), 32'(tbl[i].err));
      check($sformatf("v%0d_busy_c0", i),
            32'(busy), 32'd0);
      if (tbl[i].err) begin
        cnt_a = 0;
        cnt_b = 0;
        repeat (70) begin
          tick;
          cnt_a += int'(freq_valid);
          cnt_b += int'(busy);
        end
        check($sformatf("v%0d_no_valid", i),
              32'(cnt_a), 32'd0);
        check($sformatf("v%0d_no_busy", i),
              32'(cnt_b), 32'd0);
        check($sformatf("v%0d_err_end", i),
              32'(div_err), 32'd0);
        check($sformatf("v%0d_freq_hold", i),
              freq_hz, exp_f);
      end else begin
        n     = 0;
        busy1 = 1'b0;
        while (!freq_valid && n < 100) begin
          tick;
          n++;
          if (n == 1) busy1 = busy;
        end
        check($sformatf("v%0d_latency", i),
              32'(n), 32'd66);
        check($sformatf("v%0d_busy_c1", i),
              32'(busy1), 32'd1);
        check($sformatf("v%0d_freq_hz", i),
              freq_hz, exp_f);
        check($sformatf("v%0d_busy_c66", i),
              32'(busy), 32'd1);
        tick;
        check($sformatf("v%0d_valid_1cyc", i),
              32'(freq_valid), 32'd0);
        check($sformatf("v%0d_busy_fall", i),
              32'(busy), 32'd0);
        check($sformatf("v%0d_sig_lost", i),
              32'(sig_lost), 32'd0);
      end
      irq = 1'b0;
      tick;
      tick;
    end

    // Second irq edge in DIV: dropped, first result stands.
    cnt_x = 32'd1_000_000;
    cnt_s = 32'd100_000_000;
    irq   = 1'b1;
    tick;
    irq = 1'b0;
    n   = 0;
    repeat (30) begin
      tick;
      n++;
    end
    cnt_x = 32'd2;
    cnt_s = 32'd3;
    irq   = 1'b1;
    tick;
    n++;
    check("drop_pulse", 32'(drop), 32'd1);
    tick;
    n++;
    check("drop_end", 32'(drop), 32'd0);
    while (!freq_valid && n < 100) begin
      tick;
      n++;
    end
    check("drop_latency", 32'(n), 32'd66);
    check("drop_freq_hz", freq_hz, 32'd1_000_000);
    cnt_a = 0;
    repeat (80) begin
      tick;
      cnt_a += int'(freq_valid);
    end
    check("drop_one_result", 32'(cnt_a), 32'd0);
    irq = 1'b0;
    tick;

    // Reset in DIV cycle 10: everything clears, no result.
    cnt_x = 32'd2;
    cnt_s = 32'd3;
    irq   = 1'b1;
    tick;
    repeat (11) tick;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    irq = 1'b0;
    tick;
    check("mid_freq_hz", freq_hz, 32'd0);
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_valid", 32'(freq_valid), 32'd0);
    check("mid_sig_lost", 32'(sig_lost), 32'd0);
    rst   = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    repeat (80) begin
      tick;
      cnt_a += int'(freq_valid);
      cnt_b += int'(busy);
    end
    check("mid_no_result", 32'(cnt_a), 32'd0);
    check("mid_idle", 32'(cnt_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
